// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared types, helpers and default parameter values for the one-hot pulse decoder.
package dec_pkg;

    // Pulse sequencer states. The prefix keeps the names clear of the GAP parameter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_IDX_W = 2;
    localparam int DEF_HOLD  = 4;
    localparam int DEF_GAP   = 1;
    localparam int DEF_DEPTH = 4;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_bin2onehot.sv
// Binary index to one-hot code converter (purely combinational).
module bin2onehot
    import dec_pkg::*;
#(
    parameter  int IDX_W = DEF_IDX_W,
    localparam int OUT_W = 1 << IDX_W
) (
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] y
);

    // Drive exactly the bit selected by idx.
    // NOTE: the '0 default before the indexed write means every path assigns y, so no latch is inferred.
    always_comb begin
        y      = '0;
        y[idx] = 1'b1;
    end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Buffers binary indices in a small FIFO and replays each one as a one-hot pulse
// held for HOLD cycles, followed by GAP all-zero cycles.
module onehot_pulse_decoder
    import dec_pkg::*;
#(
    parameter  int IDX_W = DEF_IDX_W,
    parameter  int HOLD  = DEF_HOLD,
    parameter  int GAP   = DEF_GAP,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int OUT_W = 1 << IDX_W,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic             pulse_done,
    output logic [CNT_W-1:0] fifo_cnt
);

    // Cycle counter must hold HOLD-1 and GAP-1.
    localparam int TMR_W = clog2(max_int(HOLD, GAP)) + 1;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP > 0) ? GAP - 1 : 0);

    // ---------------------------------------------------------------- FIFO
    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] rd_data;
    logic [OUT_W-1:0] rd_onehot;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // No pass-through when full: a pop in the same cycle does not open the input.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign fifo_cnt = count;
    assign rd_data  = mem[rd_ptr];

    // Write accepted indices into the storage array.
    // NOTE: the storage array has no reset; the count and pointers decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_idx;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    bin2onehot #(
        .IDX_W (IDX_W)
    ) u_bin2onehot (
        .idx (rd_data),
        .y   (rd_onehot)
    );

    // ---------------------------------------------------------------- Pulse sequencer
    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic [OUT_W-1:0] y_q;
    logic [OUT_W-1:0] y_d;
    logic             y_valid_q;
    logic             y_valid_d;

    // Next-state logic: load a new code from the FIFO, time the hold and gap phases.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    y_d       = rd_onehot;
                    y_valid_d = 1'b1;
                    cnt_d     = HOLD_LOAD;
                    state_d   = ST_DRIVE;
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end
            end

            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TMR_W'(1);
                end else if (GAP > 0) begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    cnt_d     = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (!empty) begin
                    // Back-to-back reload with no idle cycle between pulses.
                    pop       = 1'b1;
                    y_d       = rd_onehot;
                    y_valid_d = 1'b1;
                    cnt_d     = HOLD_LOAD;
                    state_d   = ST_DRIVE;
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TMR_W'(1);
                end else if (!empty) begin
                    pop       = 1'b1;
                    y_d       = rd_onehot;
                    y_valid_d = 1'b1;
                    cnt_d     = HOLD_LOAD;
                    state_d   = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                y_d       = '0;
                y_valid_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any pulse in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign pulse_done = (state_q == ST_DRIVE) && (cnt_q == '0);

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: one instance with GAP=1, one with GAP=0.
module tb_onehot_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic [3:0] y;
    logic       y_valid;
    logic       pulse_done;
    logic [2:0] fifo_cnt;

    logic       in_valid_b;
    logic       in_ready_b;
    logic [1:0] in_idx_b;
    logic [3:0] y_b;
    logic       y_valid_b;
    logic       pulse_done_b;
    logic [2:0] fifo_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [1:0] send [8];
    logic [3:0] codes3 [3];
    logic [3:0] expv;
    logic [3:0] any_y;
    logic       any_flag;
    logic       acc;
    int         sidx;
    int         max_cnt;

    always #5 clk = ~clk;

    onehot_pulse_decoder #(.IDX_W(2), .HOLD(4), .GAP(1), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .y          (y),
        .y_valid    (y_valid),
        .pulse_done (pulse_done),
        .fifo_cnt   (fifo_cnt)
    );

    onehot_pulse_decoder #(.IDX_W(2), .HOLD(4), .GAP(0), .DEPTH(4)) dut_g0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_idx     (in_idx_b),
        .y          (y_b),
        .y_valid    (y_valid_b),
        .pulse_done (pulse_done_b),
        .fifo_cnt   (fifo_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_idx     = 2'd0;
        in_valid_b = 1'b0;
        in_idx_b   = 2'd0;
        send       = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        codes3     = '{4'b0001, 4'b0010, 4'b1000};

        // 1. Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_y", y, 4'b0000);
        check("rst_y_valid", y_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fifo_cnt", fifo_cnt, 3'd0);
        check("rst_pulse_done", pulse_done, 1'b0);

        // 2. Single push of idx 2
        in_valid = 1'b1;
        in_idx   = 2'd2;
        tick();
        in_valid = 1'b0;
        check("t2_E_y", y, 4'b0000);
        check("t2_E_cnt", fifo_cnt, 3'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t2_y_%0d", k), y, 4'b0100);
            check($sformatf("t2_yv_%0d", k), y_valid, 1'b1);
            check($sformatf("t2_pd_%0d", k), pulse_done, (k == 4) ? 1'b1 : 1'b0);
        end
        tick();
        check("t2_fall_y", y, 4'b0000);
        check("t2_fall_yv", y_valid, 1'b0);
        check("t2_fall_pd", pulse_done, 1'b0);
        tick();
        check("t2_idle_y", y, 4'b0000);

        // 3. Push 0,1,3 back-to-back: 0001 x4, 0 x1, 0010 x4, 0 x1, 1000 x4
        in_valid = 1'b1;
        in_idx   = 2'd0;
        tick();
        check("t3_E_y", y, 4'b0000);
        in_idx = 2'd1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (t == 1) in_idx = 2'd3;
            if (t == 2) in_valid = 1'b0;
            expv = (((t - 1) % 5) < 4 && ((t - 1) / 5) < 3) ? codes3[(t - 1) / 5] : 4'b0000;
            check($sformatf("t3_y_%0d", t), y, expv);
            check($sformatf("t3_yv_%0d", t), y_valid, (expv != 4'b0000));
        end
        tick();
        tick();
        tick();
        check("t3_end_cnt", fifo_cnt, 3'd0);

        // 4. in_valid held 8 cycles while the FIFO backs up
        sidx    = 0;
        max_cnt = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            in_valid = (cyc < 8);
            in_idx   = send[(sidx < 8) ? sidx : 7];
            acc      = in_valid && in_ready;
            tick();
            if (acc) begin
                exp_q.push_back(4'b0001 << in_idx);
                sidx++;
            end
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            if (cyc == 4) begin
                check("t4_full_cnt", fifo_cnt, 3'd4);
                check("t4_full_ready", in_ready, 1'b0);
            end
            if (pulse_done) got_q.push_back(y);
        end
        in_valid = 1'b0;
        check("t4_accepted", sidx, 6);
        check("t4_max_cnt", max_cnt, 4);
        check("t4_pulses", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size() && i < exp_q.size()) begin
                check($sformatf("t4_code_%0d", i), got_q[i], exp_q[i]);
            end
        end
        check("t4_drained", fifo_cnt, 3'd0);

        // 5. GAP=0 instance: push 1 then 2, pulses abut with no zero cycle
        in_valid_b = 1'b1;
        in_idx_b   = 2'd1;
        tick();
        check("t5_E_y", y_b, 4'b0000);
        check("t5_E_cnt", fifo_cnt_b, 3'd1);
        in_idx_b = 2'd2;
        for (int t = 1; t <= 9; t++) begin
            tick();
            in_valid_b = 1'b0;
            expv = (t <= 4) ? 4'b0010 : (t <= 8) ? 4'b0100 : 4'b0000;
            check($sformatf("t5_y_%0d", t), y_b, expv);
            check($sformatf("t5_pd_%0d", t), pulse_done_b, (t == 4 || t == 8) ? 1'b1 : 1'b0);
        end

        // 6. Reset mid-DRIVE with two entries queued
        in_valid = 1'b1;
        in_idx   = 2'd0;
        tick();
        in_idx = 2'd1;
        tick();
        in_idx = 2'd2;
        tick();
        in_valid = 1'b0;
        check("t6_pre_cnt", fifo_cnt, 3'd2);
        check("t6_pre_y", y, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_y", y, 4'b0000);
        check("t6_rst_yv", y_valid, 1'b0);
        check("t6_rst_cnt", fifo_cnt, 3'd0);
        check("t6_rst_ready", in_ready, 1'b1);
        any_y    = 4'b0000;
        any_flag = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            any_y    = any_y | y;
            any_flag = any_flag | y_valid | pulse_done | (fifo_cnt != 3'd0);
        end
        check("t6_no_stale_y", any_y, 4'b0000);
        check("t6_no_stale_flags", any_flag, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
